// File: rtl/timer_master_pkg.sv
// Shared types, register map and control bits for the Avalon timer master.
package timer_master_pkg;

    localparam int unsigned AV_ADDR_W = 3;
    localparam int unsigned AV_DATA_W = 16;
    localparam int unsigned PERIOD_W  = 32;
    localparam int unsigned SNAP_W    = 32;

    localparam logic [AV_ADDR_W-1:0] ADDR_STATUS   = 3'd0;
    localparam logic [AV_ADDR_W-1:0] ADDR_CONTROL  = 3'd1;
    localparam logic [AV_ADDR_W-1:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [AV_ADDR_W-1:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [AV_ADDR_W-1:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [AV_ADDR_W-1:0] ADDR_SNAP_H   = 3'd5;

    localparam logic [AV_DATA_W-1:0] CTL_ITO   = 16'h0001;
    localparam logic [AV_DATA_W-1:0] CTL_CONT  = 16'h0002;
    localparam logic [AV_DATA_W-1:0] CTL_START = 16'h0004;
    localparam logic [AV_DATA_W-1:0] CTL_STOP  = 16'h0008;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTL,
        RUN,
        CLR_TO,
        WR_SNAP,
        RD_SL,
        RD_SH,
        RD_DONE,
        WR_STOP
    } state_t;

    // One bus cycle as presented to the timer slave.
    typedef struct packed {
        logic                 chipselect;
        logic                 write_n;
        logic [AV_ADDR_W-1:0] address;
        logic [AV_DATA_W-1:0] writedata;
    } av_cmd_t;

    localparam av_cmd_t AV_CMD_IDLE = '{chipselect: 1'b0, write_n: 1'b1,
                                        address: '0, writedata: '0};

    function automatic av_cmd_t av_write(input logic [AV_ADDR_W-1:0] addr,
                                         input logic [AV_DATA_W-1:0] data);
        return '{chipselect: 1'b1, write_n: 1'b0, address: addr, writedata: data};
    endfunction

    function automatic av_cmd_t av_read(input logic [AV_ADDR_W-1:0] addr);
        return '{chipselect: 1'b1, write_n: 1'b1, address: addr, writedata: '0};
    endfunction

endpackage

// File: rtl/timer_master_ctl_if.sv
// Avalon-MM link between the timer master and the timer slave.
interface timer_master_ctl_if;
    import timer_master_pkg::*;

    logic [AV_ADDR_W-1:0] av_address;
    logic                 av_chipselect;
    logic                 av_write_n;
    logic [AV_DATA_W-1:0] av_writedata;
    logic [AV_DATA_W-1:0] av_readdata;
    logic                 av_irq;

    modport master (
        output av_address, av_chipselect, av_write_n, av_writedata,
        input  av_readdata, av_irq
    );

    modport slave (
        input  av_address, av_chipselect, av_write_n, av_writedata,
        output av_readdata, av_irq
    );
endinterface

// File: rtl/timer_master_ctl.sv
// Programs, services and snapshots an Avalon interval timer slave.
module timer_master_ctl
    import timer_master_pkg::*;
#(
    parameter int unsigned TICK_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    input  logic                stop,
    input  logic                snap_req,
    output logic                busy,
    output logic [TICK_W-1:0]   tick_count,
    output logic [SNAP_W-1:0]   snap_value,
    output logic                snap_valid,
    timer_master_ctl_if.master  av
);

    state_t              state;
    state_t              state_nxt;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_src;
    av_cmd_t             cmd_nxt;
    av_cmd_t             cmd_q;

    // Next state, plus the bus cycle belonging to that state so it can be registered.
    always_comb begin
        state_nxt  = state;
        cmd_nxt    = AV_CMD_IDLE;
        period_src = (state == IDLE) ? period : period_q;

        case (state)
            IDLE:    if (start && (period != '0)) state_nxt = WR_PL;
            WR_PL:   state_nxt = WR_PH;
            WR_PH:   state_nxt = WR_CTL;
            WR_CTL:  state_nxt = RUN;
            RUN: begin
                if (stop)           state_nxt = WR_STOP;
                else if (av.av_irq) state_nxt = CLR_TO;
                else if (snap_req)  state_nxt = WR_SNAP;
            end
            CLR_TO:  state_nxt = RUN;
            WR_SNAP: state_nxt = RD_SL;
            RD_SL:   state_nxt = RD_SH;
            RD_SH:   state_nxt = RD_DONE;
            RD_DONE: state_nxt = RUN;
            WR_STOP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            WR_PL:   cmd_nxt = av_write(ADDR_PERIOD_L, period_src[AV_DATA_W-1:0]);
            WR_PH:   cmd_nxt = av_write(ADDR_PERIOD_H, period_src[PERIOD_W-1:AV_DATA_W]);
            WR_CTL:  cmd_nxt = av_write(ADDR_CONTROL, CTL_ITO | CTL_CONT | CTL_START);
            CLR_TO:  cmd_nxt = av_write(ADDR_STATUS, '0);
            WR_SNAP: cmd_nxt = av_write(ADDR_SNAP_L, '0);
            RD_SL:   cmd_nxt = av_read(ADDR_SNAP_L);
            RD_SH:   cmd_nxt = av_read(ADDR_SNAP_H);
            WR_STOP: cmd_nxt = av_write(ADDR_CONTROL, CTL_STOP);
            default: cmd_nxt = AV_CMD_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Bus register: tracks the state one-for-one, so the bus is a pure function of state.
    always_ff @(posedge clk) begin
        if (reset) cmd_q <= AV_CMD_IDLE;
        else       cmd_q <= cmd_nxt;
    end

    assign av.av_chipselect = cmd_q.chipselect;
    assign av.av_write_n    = cmd_q.write_n;
    assign av.av_address    = cmd_q.address;
    assign av.av_writedata  = cmd_q.writedata;

    // Period latch, busy flag, timeout counter and snapshot capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q   <= '0;
            busy       <= 1'b0;
            tick_count <= '0;
            snap_value <= '0;
            snap_valid <= 1'b0;
        end else begin
            busy       <= (state_nxt != IDLE);
            snap_valid <= 1'b0;
            if ((state == IDLE) && (state_nxt == WR_PL)) period_q <= period;
            if (state == CLR_TO) tick_count <= tick_count + TICK_W'(1);
            if (state == RD_SH) snap_value[AV_DATA_W-1:0] <= av.av_readdata;
            if (state == RD_DONE) begin
                snap_value[SNAP_W-1:AV_DATA_W] <= av.av_readdata;
                snap_valid                     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timer_master_ctl.sv
// Bench for timer_master_ctl against a behavioural interval-timer slave.
module tb_timer_master_ctl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] period;
    logic        stop;
    logic        snap_req;
    logic        busy;
    logic [31:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;

    timer_master_ctl_if av_if();

    timer_master_ctl #(.TICK_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .period     (period),
        .stop       (stop),
        .snap_req   (snap_req),
        .busy       (busy),
        .tick_count (tick_count),
        .snap_value (snap_value),
        .snap_valid (snap_valid),
        .av         (av_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural timer slave ----------------
    logic [15:0] s_per_l, s_per_h, s_rdata;
    logic        s_run, s_ito, s_cont, s_to;
    logic [31:0] s_cnt, s_snap;
    int          model_ticks;   // timeouts the slave delivered and saw acknowledged

    always @(posedge clk) begin
        logic fire;
        fire = 1'b0;
        if (reset) begin
            s_per_l <= '0; s_per_h <= '0; s_rdata <= '0;
            s_run <= 1'b0; s_ito <= 1'b0; s_cont <= 1'b0; s_to <= 1'b0;
            s_cnt <= '0; s_snap <= '0; model_ticks <= 0;
        end else begin
            if (av_if.av_chipselect) begin
                case (av_if.av_address)
                    3'd0:    s_rdata <= {14'd0, s_run, s_to};
                    3'd1:    s_rdata <= {13'd0, s_cont & s_run, s_cont, s_ito};
                    3'd2:    s_rdata <= s_per_l;
                    3'd3:    s_rdata <= s_per_h;
                    3'd4:    s_rdata <= s_snap[15:0];
                    3'd5:    s_rdata <= s_snap[31:16];
                    default: s_rdata <= '0;
                endcase
            end
            if (s_run) begin
                if (s_cnt == 0) begin
                    fire = 1'b1;
                    s_cnt <= {s_per_h, s_per_l};
                    if (!s_cont) s_run <= 1'b0;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
            if (av_if.av_chipselect && !av_if.av_write_n) begin
                case (av_if.av_address)
                    3'd0: begin
                        if (s_to) model_ticks <= model_ticks + 1;
                        s_to <= 1'b0;
                    end
                    3'd1: begin
                        s_ito  <= av_if.av_writedata[0];
                        s_cont <= av_if.av_writedata[1];
                        if (av_if.av_writedata[2]) begin
                            s_run <= 1'b1;
                            s_cnt <= {s_per_h, s_per_l};
                        end
                        if (av_if.av_writedata[3]) s_run <= 1'b0;
                    end
                    3'd2: s_per_l <= av_if.av_writedata;
                    3'd3: s_per_h <= av_if.av_writedata;
                    3'd4, 3'd5: s_snap <= s_cnt;
                    default: ;
                endcase
            end
            if (fire) s_to <= 1'b1;
        end
    end

    assign av_if.av_readdata = s_rdata;
    assign av_if.av_irq      = s_to & s_ito;

    // ---------------- passive monitor ----------------
    int mon_starts  = 0;
    int mon_snaps   = 0;
    int irq_streak  = 0;

    always @(negedge clk) begin
        if (av_if.av_chipselect && !av_if.av_write_n && av_if.av_address == 3'd2) mon_starts++;
        if (snap_valid) begin
            mon_snaps++;
            check("snap_match", 64'(snap_value), 64'(s_snap));
        end
        if (av_if.av_irq && busy) irq_streak++;
        else if (!av_if.av_irq && irq_streak > 0) begin
            check("irq_wait", 64'(irq_streak <= 8), 64'd1);
            irq_streak = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    function automatic bit in_run();
        return busy && !av_if.av_chipselect;
    endfunction

    task automatic expect_bus(input string tag, input logic cs, input logic wn,
                              input logic [2:0] a, input logic [15:0] d);
        check(tag, 64'({av_if.av_chipselect, av_if.av_write_n, av_if.av_address, av_if.av_writedata}),
                   64'({cs, wn, a, d}));
    endtask

    task automatic do_start(input string tag, input logic [31:0] p);
        start = 1'b1; period = p; step(); start = 1'b0;
        expect_bus({tag, "_pl"}, 1'b1, 1'b0, 3'd2, p[15:0]);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        step(); expect_bus({tag, "_ph"}, 1'b1, 1'b0, 3'd3, p[31:16]);
        step(); expect_bus({tag, "_ctl"}, 1'b1, 1'b0, 3'd1, 16'h0007);
        step(); expect_bus({tag, "_run"}, 1'b0, 1'b1, 3'd0, 16'h0000);
    endtask

    task automatic do_stop(input string tag);
        int n;
        n = 0;
        while (!in_run() && n < 50) begin step(); n++; end
        stop = 1'b1; step(); stop = 1'b0;
        expect_bus({tag, "_wr"}, 1'b1, 1'b0, 3'd1, 16'h0008);
        step();
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          budget, lat, n, cs_seen, busy_seen, r;
        int          base_starts, base_snaps, exp_starts, exp_snaps;
        bit          pend;
        logic [31:0] p;

        reset = 1'b1; start = 1'b0; stop = 1'b0; snap_req = 1'b0; period = '0;
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tick", 64'(tick_count), 64'd0);
        check("rst_snap", 64'(snap_value), 64'd0);
        check("rst_snap_valid", 64'(snap_valid), 64'd0);
        expect_bus("rst_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
        reset = 1'b0; step();

        // program and run with a short period
        do_start("p5", 32'h0000_0005);

        // three timeouts, each acknowledged promptly
        budget = 0; pend = 1'b0; lat = 0;
        while (tick_count != 3 && budget < 200) begin
            step(); budget++;
            if (pend) begin
                lat++;
                if (av_if.av_chipselect && !av_if.av_write_n && av_if.av_address == 3'd0) begin
                    check("irq_clr_lat", 64'(lat <= 2), 64'd1);
                    pend = 1'b0;
                end
            end else if (av_if.av_irq) begin
                pend = 1'b1; lat = 0;
            end
        end
        check("ticks_3", 64'(tick_count), 64'd3);
        check("model_ticks_3", 64'(model_ticks), 64'd3);

        // snapshot with a long period
        do_stop("stop1");
        do_start("slow", 32'h0001_869F);
        base_snaps = mon_snaps;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        expect_bus("snap_wr", 1'b1, 1'b0, 3'd4, 16'h0000);
        step(); expect_bus("snap_rd_l", 1'b1, 1'b1, 3'd4, 16'h0000);
        step(); expect_bus("snap_rd_h", 1'b1, 1'b1, 3'd5, 16'h0000);
        step(); expect_bus("snap_done", 1'b0, 1'b1, 3'd0, 16'h0000);
        step();
        check("snap_valid", 64'(snap_valid), 64'd1);
        check("snap_value_abs", 64'(snap_value), 64'h0001_869E);
        step(); step();
        check("snap_pulses", 64'(mon_snaps - base_snaps), 64'd1);
        check("snap_tick_kept", 64'(tick_count), 64'd3);

        // stop and timeout in the same cycle
        do_stop("stop2");
        do_start("fast", 32'd7);
        n = 0;
        while (!(av_if.av_irq && in_run()) && n < 100) begin step(); n++; end
        stop = 1'b1; step(); stop = 1'b0;
        expect_bus("stopirq_wr", 1'b1, 1'b0, 3'd1, 16'h0008);
        step();
        check("stopirq_busy", 64'(busy), 64'd0);
        check("stopirq_tick", 64'(tick_count), 64'd3);

        // zero period is ignored
        start = 1'b1; period = '0; step(); start = 1'b0;
        cs_seen = 0; busy_seen = 0;
        repeat (6) begin
            if (av_if.av_chipselect) cs_seen++;
            if (busy) busy_seen++;
            step();
        end
        check("p0_bus", 64'(cs_seen), 64'd0);
        check("p0_busy", 64'(busy_seen), 64'd0);

        // reset in the middle of programming
        p = 32'($urandom_range(100000, 900000));
        start = 1'b1; period = p; step(); start = 1'b0;
        step(); expect_bus("pre_rst_ph", 1'b1, 1'b0, 3'd3, p[31:16]);
        reset = 1'b1; step();
        expect_bus("rst_mid_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_tick", 64'(tick_count), 64'd0);
        check("rst_mid_snap", 64'(snap_value), 64'd0);
        reset = 1'b0; step();

        // randomized operation mix against the reference counts
        base_starts = mon_starts; base_snaps = mon_snaps;
        exp_starts = 0; exp_snaps = 0;
        for (int op = 0; op < 60; op++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                p = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(8, 40));
                if (!busy && p != 0) exp_starts++;
                start = 1'b1; period = p; step(); start = 1'b0;
            end else if (r < 6) begin
                if (in_run() && !av_if.av_irq) exp_snaps++;
                snap_req = 1'b1; step(); snap_req = 1'b0;
            end else if (r < 7) begin
                stop = 1'b1; step(); stop = 1'b0;
            end
            repeat ($urandom_range(0, 10)) step();
            check("rnd_tick", 64'(tick_count), 64'(model_ticks));
        end
        repeat (8) step();
        check("rnd_starts", 64'(mon_starts - base_starts), 64'(exp_starts));
        check("rnd_snaps", 64'(mon_snaps - base_snaps), 64'(exp_snaps));
        check("rnd_tick_end", 64'(tick_count), 64'(model_ticks));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_master_ctl.md
TIMER_MASTER_CTL -- requirements
Module: timer_master_ctl

Interface
REQ-001 Parameter TICK_W, default 32, width of tick_count.
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  one-cycle request to program and start the timer.
REQ-005 period  input  32  timer period; sampled when start is accepted.
REQ-006 stop  input  1  one-cycle request to stop the timer.
REQ-007 snap_req  input  1  one-cycle request to read a counter snapshot.
REQ-008 busy  output  1  high from start acceptance until stop completes.
REQ-009 tick_count  output  TICK_W  number of timeouts serviced.
REQ-010 snap_value  output  32  last snapshot read from the timer.
REQ-011 snap_valid  output  1  one-cycle pulse when snap_value updates.
REQ-012 av_address  output  3  Avalon-MM word address to the timer slave.
REQ-013 av_chipselect  output  1  Avalon-MM chip select.
REQ-014 av_write_n  output  1  Avalon-MM active-low write strobe.
REQ-015 av_writedata  output  16  Avalon-MM write data.
REQ-016 av_readdata  input  16  Avalon-MM read data; registered by the slave, valid one cycle after the address is driven.
REQ-017 av_irq  input  1  timer interrupt, level, high until the status register is written.

Function
REQ-018 The slave map SHALL be: 0 = status (write clears timeout), 1 = control, 2 = period_l, 3 = period_h, 4 = snap_l, 5 = snap_h; writing 4 or 5 captures the snapshot.
REQ-019 The slave has no waitrequest; each write SHALL occupy exactly one cycle (chipselect=1, write_n=0).
REQ-020 Bus outputs SHALL be decoded from the registered state (Moore); idle bus = chipselect 0, write_n 1, address 0, writedata 0.
REQ-021 FSM states SHALL be IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR_TO, WR_SNAP, RD_SL, RD_SH, RD_DONE, WR_STOP.
REQ-022 IDLE: start with period!=0 -> latch period, go WR_PL; start with period==0 SHALL be ignored.
REQ-023 WR_PL writes period[15:0] to addr 2; WR_PH writes period[31:16] to addr 3; WR_CTL writes 0x0007 (ITO|CONT|START) to addr 1; then RUN.
REQ-024 RUN priority per cycle: stop -> WR_STOP; else av_irq -> CLR_TO; else snap_req -> WR_SNAP.
REQ-025 CLR_TO writes 0x0000 to addr 0; tick_count increments by 1 on that cycle, wrapping from all-ones to 0; return RUN.
REQ-026 Snapshot sequence: WR_SNAP writes 0x0000 to addr 4; RD_SL drives read at addr 4; RD_SH drives read at addr 5 and captures av_readdata into snap_value[15:0]; RD_DONE captures av_readdata into snap_value[31:16], pulses snap_valid, returns RUN.
REQ-027 Reads SHALL drive chipselect=1, write_n=1.
REQ-028 WR_STOP writes 0x0008 (STOP) to addr 1, then IDLE; busy deasserts on entry to IDLE.
REQ-029 start while busy, and stop/snap_req outside RUN, SHALL be ignored (no queuing).
REQ-030 stop and av_irq in the same RUN cycle: stop wins; the pending timeout is not counted.
REQ-031 av_irq arriving during the snapshot sequence SHALL be serviced on the next RUN cycle; no timeout is lost.
REQ-032 tick_count SHALL be preserved across stop/start; only reset clears it.

Reset
REQ-033 reset SHALL force IDLE, busy 0, tick_count 0, snap_value 0, snap_valid 0, and an idle bus at the next clock edge, including mid-sequence.

Structure
REQ-034 Package timer_master_pkg SHALL hold the register addresses, control bit masks (ITO=0x1, CONT=0x2, START=0x4, STOP=0x8), and the state enum.
REQ-035 Single module; no sub-module.

Verification (bench uses the existing timer slave as the responder)
REQ-036 start, period=0x00000005 -> writes addr2=0x0005, addr3=0x0000, addr1=0x0007 on three consecutive cycles; busy=1.
REQ-037 Run for 3 timeouts -> each irq is cleared via an addr0 write within 2 cycles; tick_count=3.
REQ-038 period=0x0001869F, snap_req in RUN -> addr4 write, then reads of addr4 and addr5; snap_valid pulses once; snap_value equals the slave's counter_snapshot.
REQ-039 stop and irq in the same cycle -> addr1=0x0008 written; IDLE; tick_count unchanged.
REQ-040 start with period=0 -> no bus activity; busy stays 0.
REQ-041 reset asserted during WR_PH -> next cycle chipselect=0, busy=0, tick_count=0.
